vlc_rx_deframer: RTL and testbench
==================================

// Module: vlc_rx_deframer
// PURPOSE
//  Downstream consumer of the receiver's divided sample clock (pclk).
//  Oversamples the photodiode comparator bit at the pclk rate and locates start bits.
//  Samples each data bit at mid-symbol and assembles UART-style OOK frames into bytes.
//  Hands each byte to the decode stage over a valid/ready interface with a one-deep holding register.
//  Runs entirely in the aclk domain. pclk is treated as data: its rising edge is a one-cycle sample strobe.
// PARAMETERS
//  OVERSAMPLE  8  pclk rising edges per symbol; even, >=4
//  DATA_BITS   8  payload bits per frame, LSB first
// PORTS
//  aclk       in   1          system clock; all logic on posedge
//  resetn     in   1          asynchronous, active-low reset
//  pclk       in   1          divided sample clock, generated from aclk
//  rx_in      in   1          raw comparator output; idle=1, asynchronous to aclk
//  m_data     out  DATA_BITS  received byte; held stable while m_valid=1
//  m_valid    out  1          byte available
//  m_ready    in   1          consumer accepts; transfer when m_valid && m_ready
//  frame_err  out  1          1-cycle pulse: stop bit sampled as 0
//  overrun    out  1          1-cycle pulse: byte completed while holding register full
//  busy       out  1          1 while FSM is not in IDLE
// BEHAVIOUR
//  Reset values (resetn=0, async): m_data=0, m_valid=0, frame_err=0, overrun=0, busy=0.
//   Reset also forces FSM=IDLE, counters=0, synchroniser FFs=1, pclk_d=0.
//   A partial frame in flight when reset is applied is discarded.
//  Synchroniser: rx_in passes through 2 FFs to give rx_s. pclk is registered once to give pclk_d.
//  Tick: tick = pclk & ~pclk_d (one aclk cycle per pclk rising edge). All FSM decisions occur only on tick cycles.
//  Tick counter cnt has width clog2(OVERSAMPLE). HALF = OVERSAMPLE/2.
//  FSM states and transitions:
//   IDLE: on a tick with rx_s==0 -> START, cnt=0.
//   START: cnt increments each tick. At cnt==HALF-1 (mid start bit):
//    rx_s==1 -> IDLE (glitch rejected, no output).
//    rx_s==0 -> DATA, cnt=0, bit index=0.
//   DATA: at cnt==OVERSAMPLE-1, shift rx_s into the shift register at position bit index (LSB first), then cnt=0.
//    After DATA_BITS samples -> STOP.
//   STOP: at cnt==OVERSAMPLE-1, sample the stop bit, then -> IDLE on the same tick:
//    rx_s==1: frame good.
//    rx_s==0: frame_err pulses 1 cycle; byte discarded.
//   Back-to-back frames are supported: a start edge may be detected on the first tick after returning to IDLE.
//  Output register:
//   A good frame with m_valid==0 loads m_data and sets m_valid on the next aclk edge. Latency is 1 aclk after the stop-sample tick.
//   m_valid clears on the cycle after m_valid && m_ready.
//   A good frame with m_valid==1 and m_ready==0 in the same cycle: overrun pulses. The old byte is kept and the new byte is dropped.
//   A good frame with m_valid==1 and m_ready==1 in the same cycle: the old byte transfers, the new byte loads, m_valid stays 1, no overrun.
//  Wrap-around: cnt and bit index reset on every state change. There is no free-running overflow.
//  pclk held static: no ticks occur, the FSM freezes in its current state, and outputs hold.
// TESTING (OVERSAMPLE=8, DATA_BITS=8, pclk period 6 aclk, one symbol = 48 aclk)
//  1. Frame 0xA5 with m_ready=1 -> m_data=8'hA5, m_valid for exactly 1 cycle, frame_err=0, overrun=0.
//  2. rx_in low for 2 ticks (shorter than HALF) in IDLE -> busy rises then falls, no m_valid, no frame_err.
//  3. Frame 0x3C with stop bit forced 0 -> frame_err 1-cycle pulse, m_valid stays 0.
//  4. m_ready=0; frames 0x11 then 0x22 sent -> m_data=8'h11 held, overrun pulses once. Then m_ready=1 -> 8'h11 accepted, m_valid=0.
//  5. Frames 0x00 and 0xFF back-to-back with no idle gap, m_ready=1 -> both bytes delivered in order, no errors.
//  6. resetn=0 mid-way through data bit 4 of frame 0x5A, then released -> all outputs 0, FSM in IDLE. Next full frame 0xC3 -> 8'hC3 delivered.

Source files
------------

// File: rtl/vlc_rx_deframer.sv
// vlc_rx_deframer: oversampling OOK/UART-style frame receiver.
// Treats pclk as data (rising edge = sample strobe), finds start bits, samples
// each data bit mid-symbol and presents bytes on a valid/ready port backed by a
// one-deep holding register.
module vlc_rx_deframer #(
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 aclk,
  input  logic                 resetn,
  input  logic                 pclk,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CntW-1:0] CntHalfLast = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] CntLast     = CntW'(OVERSAMPLE - 1);
  localparam logic [IdxW-1:0] IdxLast     = IdxW'(DATA_BITS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 rx_meta_q, rx_s_q, pclk_d_q;
  logic                 tick;
  logic                 frame_good, frame_bad;

  // Two-stage synchroniser for rx_in (idle high) and pclk edge-detect register.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      pclk_d_q  <= 1'b0;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
      pclk_d_q  <= pclk;
    end
  end

  assign tick = pclk & ~pclk_d_q;

  // FSM and datapath state registers; a reset discards any partial frame.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state logic; every decision is qualified by tick so a static pclk freezes the FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            state_d = StStart;
            cnt_d   = '0;
          end
        end
        StStart: begin
          if (cnt_q == CntHalfLast) begin
            // Mid start bit: a high line here means the falling edge was a glitch.
            cnt_d   = '0;
            idx_d   = '0;
            state_d = rx_s_q ? StIdle : StData;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == CntLast) begin
            cnt_d          = '0;
            shreg_d[idx_q] = rx_s_q;
            if (idx_q == IdxLast) begin
              idx_d   = '0;
              state_d = StStop;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (cnt_q == CntLast) begin
            cnt_d      = '0;
            state_d    = StIdle;
            frame_good = rx_s_q;
            frame_bad  = ~rx_s_q;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output holding register and 1-cycle status pulses.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_bad;
      // A full register that is not draining this cycle drops the new byte.
      overrun   <= frame_good & m_valid & ~m_ready;
      if (frame_good && (!m_valid || m_ready)) begin
        m_data  <= shreg_q;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_vlc_rx_deframer.sv
// Directed bench for vlc_rx_deframer with a byte scoreboard on the output port.
module tb_vlc_rx_deframer;

  localparam int Sym = 48;  // aclk cycles per symbol (pclk = aclk/6, 8 ticks per symbol)

  logic       aclk = 1'b0;
  logic       resetn = 1'b0;
  logic       pclk;
  logic       rx_in = 1'b1;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;
  int ferr_cycles = 0;
  int ovr_cycles = 0;
  int popped = 0;
  int pdiv = 0;
  logic [7:0] sb[$];

  vlc_rx_deframer #(
    .OVERSAMPLE(8),
    .DATA_BITS (8)
  ) dut (
    .aclk     (aclk),
    .resetn   (resetn),
    .pclk     (pclk),
    .rx_in    (rx_in),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 aclk = ~aclk;

  // pclk: 3 aclk high, 3 aclk low, derived from aclk.
  always @(posedge aclk) pdiv <= (pdiv == 5) ? 0 : pdiv + 1;
  assign pclk = (pdiv < 3);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: counts pulse cycles and compares each transferred byte.
  always @(negedge aclk) begin
    if (resetn) begin
      if (m_valid) valid_cycles++;
      if (frame_err) ferr_cycles++;
      if (overrun) ovr_cycles++;
      if (m_valid && m_ready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          check("sb_byte", 32'(m_data), 32'(sb.pop_front()));
          popped++;
        end
      end
    end
  end

  function automatic logic lvl(input logic [7:0] b, input logic stop, input int c);
    int s;
    s = c / Sym;
    if (s == 0) return 1'b0;
    else if (s <= 8) return b[s-1];
    else return stop;
  endfunction

  // Drives the first ncyc aclk cycles of a frame (full frame = 10 symbols).
  task automatic send(input logic [7:0] b, input logic stop, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      rx_in = lvl(b, stop, c);
      @(negedge aclk);
    end
    rx_in = 1'b1;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge aclk);
  endtask

  int v0, f0, o0, p0;
  logic saw_busy;

  initial begin
    // Reset values
    repeat (4) @(negedge aclk);
    check("rst_m_data", 32'(m_data), 32'h0);
    check("rst_m_valid", 32'(m_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    resetn = 1'b1;
    idle(20);

    // 1. Single good frame
    v0 = valid_cycles; f0 = ferr_cycles; o0 = ovr_cycles; p0 = popped;
    sb.push_back(8'hA5);
    send(8'hA5, 1'b1, 10 * Sym);
    idle(2 * Sym);
    check("t1_delivered", 32'(popped - p0), 32'd1);
    check("t1_m_data", 32'(m_data), 32'hA5);
    check("t1_valid_cycles", 32'(valid_cycles - v0), 32'd1);
    check("t1_frame_err", 32'(ferr_cycles - f0), 32'd0);
    check("t1_overrun", 32'(ovr_cycles - o0), 32'd0);

    // 2. Short glitch rejected
    v0 = valid_cycles; f0 = ferr_cycles;
    saw_busy = 1'b0;
    rx_in = 1'b0;
    repeat (12) begin
      @(negedge aclk);
      saw_busy |= busy;
    end
    rx_in = 1'b1;
    repeat (60) begin
      @(negedge aclk);
      saw_busy |= busy;
    end
    check("t2_busy_seen", 32'(saw_busy), 32'd1);
    check("t2_busy_end", 32'(busy), 32'd0);
    check("t2_no_valid", 32'(valid_cycles - v0), 32'd0);
    check("t2_no_ferr", 32'(ferr_cycles - f0), 32'd0);

    // 3. Bad stop bit
    v0 = valid_cycles; f0 = ferr_cycles; o0 = ovr_cycles;
    send(8'h3C, 1'b0, 10 * Sym);
    idle(2 * Sym);
    check("t3_ferr_cycles", 32'(ferr_cycles - f0), 32'd1);
    check("t3_no_valid", 32'(valid_cycles - v0), 32'd0);
    check("t3_no_overrun", 32'(ovr_cycles - o0), 32'd0);

    // 4. Overrun with consumer stalled
    m_ready = 1'b0;
    o0 = ovr_cycles; p0 = popped;
    sb.push_back(8'h11);
    send(8'h11, 1'b1, 10 * Sym);
    idle(Sym);
    send(8'h22, 1'b1, 10 * Sym);
    idle(2 * Sym);
    check("t4_held_valid", 32'(m_valid), 32'd1);
    check("t4_held_data", 32'(m_data), 32'h11);
    check("t4_overrun", 32'(ovr_cycles - o0), 32'd1);
    m_ready = 1'b1;
    idle(4);
    check("t4_accepted", 32'(popped - p0), 32'd1);
    check("t4_valid_clr", 32'(m_valid), 32'd0);

    // 5. Back-to-back frames
    f0 = ferr_cycles; o0 = ovr_cycles; p0 = popped;
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    send(8'h00, 1'b1, 10 * Sym);
    send(8'hFF, 1'b1, 10 * Sym);
    idle(2 * Sym);
    check("t5_delivered", 32'(popped - p0), 32'd2);
    check("t5_no_ferr", 32'(ferr_cycles - f0), 32'd0);
    check("t5_no_overrun", 32'(ovr_cycles - o0), 32'd0);

    // 6. Reset mid-frame, then a clean frame
    send(8'h5A, 1'b1, 5 * Sym + Sym / 2);
    resetn = 1'b0;
    idle(3);
    check("t6_rst_m_data", 32'(m_data), 32'h0);
    check("t6_rst_m_valid", 32'(m_valid), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_ferr", 32'(frame_err), 32'h0);
    check("t6_rst_overrun", 32'(overrun), 32'h0);
    resetn = 1'b1;
    idle(2 * Sym);
    check("t6_idle_busy", 32'(busy), 32'h0);
    p0 = popped; f0 = ferr_cycles;
    sb.push_back(8'hC3);
    send(8'hC3, 1'b1, 10 * Sym);
    idle(2 * Sym);
    check("t6_delivered", 32'(popped - p0), 32'd1);
    check("t6_m_data", 32'(m_data), 32'hC3);
    check("t6_no_ferr", 32'(ferr_cycles - f0), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
